// File: rtl/branch_target_lut_prog.sv
// Programmable branch-target table for the fetch stage. It provides a registered lookup,
// a same-cycle write bypass, a miss fall-through to Pc+1 and a sequential flush sweep.
module branch_target_lut_prog #(
   parameter int PC_W  = 16,
   parameter int IDX_W = 7,
   parameter int DEPTH = 2**IDX_W
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             WrEn,
   input  logic [IDX_W-1:0] WrIdx,
   input  logic [PC_W-1:0]  WrData,
   input  logic             WrRel,
   input  logic             Flush,
   input  logic             LookupEn,
   input  logic [IDX_W-1:0] LookupIdx,
   input  logic [PC_W-1:0]  Pc,
   output logic             TargetValid,
   output logic [PC_W-1:0]  Target,
   output logic             Miss,
   output logic             Busy
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [IDX_W-1:0] r_cnt;
   logic [DEPTH-1:0] r_valid;
   logic [PC_W-1:0]  r_data [DEPTH];
   logic             r_rel  [DEPTH];

   logic             r_tvalid;
   logic [PC_W-1:0]  r_target;
   logic             r_miss;

   logic             w_wr_in_range;
   logic             w_lk_in_range;
   logic             w_wr_ok;
   logic             w_bypass;
   logic             w_hit;
   logic [PC_W-1:0]  w_entry;
   logic             w_rel;
   logic [PC_W-1:0]  w_target;

   assign w_wr_in_range = (32'(WrIdx) < DEPTH);
   assign w_lk_in_range = (32'(LookupIdx) < DEPTH);
   // A flush in the same cycle as a write wins, so the write is dropped.
   assign w_wr_ok  = WrEn && (r_state == S_IDLE) && !Flush && w_wr_in_range;
   assign w_bypass = w_wr_ok && LookupEn && (WrIdx == LookupIdx);

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (Flush) w_next_state = S_SWEEP;
         S_SWEEP: if (r_cnt == LAST_IDX) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      Busy = (r_state == S_SWEEP);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cnt <= '0;
      end else if (r_state == S_SWEEP && r_cnt != LAST_IDX) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_valid <= '0;
      end else if (r_state == S_SWEEP) begin
         r_valid[r_cnt] <= 1'b0;
      end else if (w_wr_ok) begin
         r_valid[WrIdx] <= 1'b1;
      end
   end

   // Entry payload is not reset; only the valid bits qualify it.
   always_ff @(posedge Clk) begin
      if (w_wr_ok) begin
         r_data[WrIdx] <= WrData;
         r_rel[WrIdx]  <= WrRel;
      end
   end

   always_comb begin
      w_hit    = 1'b0;
      w_entry  = r_data[LookupIdx];
      w_rel    = r_rel[LookupIdx];
      w_target = Pc + PC_W'(1);
      if (w_bypass) begin
         w_entry = WrData;
         w_rel   = WrRel;
         w_hit   = 1'b1;
      end else if (r_state == S_IDLE && w_lk_in_range) begin
         w_hit = r_valid[LookupIdx];
      end
      if (w_hit) begin
         w_target = w_rel ? (Pc + w_entry) : w_entry;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_tvalid <= 1'b0;
         r_target <= '0;
         r_miss   <= 1'b0;
      end else begin
         r_tvalid <= LookupEn;
         if (LookupEn) begin
            r_target <= w_target;
            r_miss   <= !w_hit;
         end
      end
   end

   assign TargetValid = r_tvalid;
   assign Target      = r_target;
   assign Miss        = r_miss;

endmodule

// File: tb/tb_branch_target_lut_prog.sv
// Directed bench for branch_target_lut_prog: lookup, bypass, wrap, flush sweep and mid-sweep reset.
module tb_branch_target_lut_prog;

   localparam int PC_W  = 16;
   localparam int IDX_W = 7;
   localparam int DEPTH = 128;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             WrEn;
   logic [IDX_W-1:0] WrIdx;
   logic [PC_W-1:0]  WrData;
   logic             WrRel;
   logic             Flush;
   logic             LookupEn;
   logic [IDX_W-1:0] LookupIdx;
   logic [PC_W-1:0]  Pc;
   logic             TargetValid;
   logic [PC_W-1:0]  Target;
   logic             Miss;
   logic             Busy;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cycles;

   branch_target_lut_prog #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrIdx(WrIdx), .WrData(WrData),
      .WrRel(WrRel), .Flush(Flush), .LookupEn(LookupEn), .LookupIdx(LookupIdx),
      .Pc(Pc), .TargetValid(TargetValid), .Target(Target), .Miss(Miss), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [IDX_W-1:0] idx, input logic [PC_W-1:0] data,
                           input logic rel);
      WrEn = 1'b1; WrIdx = idx; WrData = data; WrRel = rel;
      tick();
      WrEn = 1'b0;
   endtask

   task automatic do_lookup(input string tag, input logic [IDX_W-1:0] idx,
                            input logic [PC_W-1:0] pc, input logic [PC_W-1:0] exp_tgt,
                            input logic exp_miss);
      LookupEn = 1'b1; LookupIdx = idx; Pc = pc;
      tick();
      LookupEn = 1'b0;
      check({tag, "_valid"}, 32'(TargetValid), 32'd1);
      check({tag, "_target"}, 32'(Target), 32'(exp_tgt));
      check({tag, "_miss"}, 32'(Miss), 32'(exp_miss));
   endtask

   initial begin
      Reset = 1'b1; WrEn = 1'b0; WrIdx = '0; WrData = '0; WrRel = 1'b0;
      Flush = 1'b0; LookupEn = 1'b0; LookupIdx = '0; Pc = '0;
      tick(); tick();
      check("rst_tvalid", 32'(TargetValid), 32'd0);
      check("rst_target", 32'(Target), 32'd0);
      check("rst_miss", 32'(Miss), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      Reset = 1'b0;
      tick();

      // Empty table misses with fall-through, then holds when idle
      do_lookup("empty_miss", 7'h05, 16'h0100, 16'h0101, 1'b1);
      tick();
      check("idle_tvalid", 32'(TargetValid), 32'd0);
      check("idle_hold", 32'(Target), 32'h0101);

      do_write(7'h00, 16'hFFFF, 1'b0);
      do_lookup("abs_hit", 7'h00, 16'h1234, 16'hFFFF, 1'b0);
      do_write(7'h01, 16'hFFF0, 1'b1);
      do_lookup("rel_hit", 7'h01, 16'h0008, 16'hFFF8, 1'b0);

      // Same-cycle write and lookup to the same index
      WrEn = 1'b1; WrIdx = 7'h40; WrData = 16'h0003; WrRel = 1'b0;
      LookupEn = 1'b1; LookupIdx = 7'h40; Pc = 16'h0500;
      tick();
      WrEn = 1'b0; LookupEn = 1'b0;
      check("bypass_target", 32'(Target), 32'h0003);
      check("bypass_miss", 32'(Miss), 32'd0);
      do_lookup("after_bypass", 7'h40, 16'h0600, 16'h0003, 1'b0);

      do_write(7'h02, 16'h0004, 1'b1);
      do_lookup("rel_wrap", 7'h02, 16'hFFFE, 16'h0002, 1'b0);
      do_lookup("miss_wrap", 7'h05, 16'hFFFF, 16'h0000, 1'b1);

      do_write(7'h03, 16'h0777, 1'b0);
      do_lookup("fill3", 7'h03, 16'h0000, 16'h0777, 1'b0);

      // Flush sweep: lookup, write and re-flush inside the sweep
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("sweep_busy_start", 32'(Busy), 32'd1);
      busy_cycles = 0;
      while (Busy && busy_cycles < 300) begin
         busy_cycles++;
         if (busy_cycles == 1) begin
            LookupEn = 1'b1; LookupIdx = 7'h03; Pc = 16'h0200;
         end else if (busy_cycles == 11) begin
            WrEn = 1'b1; WrIdx = 7'h02; WrData = 16'h1234; WrRel = 1'b0;
         end else if (busy_cycles == 50) begin
            Flush = 1'b1;
         end
         tick();
         if (busy_cycles == 1) begin
            check("sweep_lk_target", 32'(Target), 32'h0201);
            check("sweep_lk_miss", 32'(Miss), 32'd1);
         end
         LookupEn = 1'b0; WrEn = 1'b0; Flush = 1'b0;
      end
      check("sweep_len", 32'(busy_cycles), 32'd128);
      for (int i = 0; i < 4; i++) begin
         do_lookup("post_flush", IDX_W'(i), 16'h0300 + 16'(i), 16'h0301 + 16'(i), 1'b1);
      end

      // Reset in the middle of a sweep
      do_write(7'h00, 16'h0055, 1'b0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      check("mid_sweep_busy", 32'(Busy), 32'd1);
      Reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(Busy), 32'd0);
      check("mid_rst_tvalid", 32'(TargetValid), 32'd0);
      tick();
      Reset = 1'b0;
      tick();
      check("post_rst_busy", 32'(Busy), 32'd0);
      do_lookup("post_rst_miss", 7'h00, 16'h0010, 16'h0011, 1'b1);
      do_lookup("post_rst_miss40", 7'h40, 16'h0020, 16'h0021, 1'b1);
      do_write(7'h09, 16'h0ABC, 1'b0);
      do_lookup("post_rst_hit", 7'h09, 16'h0030, 16'h0ABC, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
